f_div_prog: RTL and testbench

//  Runtime-programmable clock-enable / divided-clock generator for the digital_tube design.

---
 rtl/f_div_prog_if.sv | 21 ++
 rtl/f_div_prog.sv | 112 +++++++++++
 tb/tb_f_div_prog.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/f_div_prog_if.sv
// Load channel for f_div_prog: a new half-period offered over a valid/ready handshake.
// The source drives load_valid/load_half (master); the divider returns load_ready (slave).
interface f_div_prog_if #(
    parameter int unsigned CNT_W = 32
);
    logic             load_valid;
    logic [CNT_W-1:0] load_half;
    logic             load_ready;

    modport master (
        output load_valid,
        output load_half,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_half,
        output load_ready
    );
endinterface

// File: rtl/f_div_prog.sv
// f_div_prog: runtime-programmable divided-clock / strobe generator on clk_50M.
// A half-period counter runs while en=1; each wrap produces a one-cycle tick and
// either toggles clk_out (mode=0) or pulses it (mode=1). A new half-period is
// accepted over the load interface, held pending, and applied only at a wrap
// (or at once while the counter is disabled), so the output never glitches.
// Optional feature: define FDIV_TICK_CNT_EN to add the 16-bit tick_cnt output.
module f_div_prog #(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned RST_HALF = 50_000_000
) (
    input  logic         clk_50M,
    input  logic         reset,
    input  logic         en,
    input  logic         mode,
    f_div_prog_if.slave  load,
    output logic         clk_out,
    output logic         tick
`ifdef FDIV_TICK_CNT_EN
    ,
    output logic [15:0]  tick_cnt
`endif
);

    localparam logic [CNT_W-1:0] RST_HALF_W = CNT_W'(RST_HALF);
    localparam logic [CNT_W-1:0] ONE_W      = CNT_W'(1);

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] pend_val_q, pend_val_d;
    logic             pend_q, pend_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             term;
    logic             accept;
`ifdef FDIV_TICK_CNT_EN
    logic [15:0]      tick_cnt_q, tick_cnt_d;
`endif

    // Ready whenever nothing is pending; forced low while reset is held.
    assign load.load_ready = !pend_q && !reset;

    // Next-state: counter wrap, output shaping, pending-divisor capture and apply.
    always_comb begin
        term       = en && (count_q == (half_q - ONE_W));
        accept     = load.load_valid && !pend_q;
        count_d    = count_q;
        half_d     = half_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        tick_d     = term;
        clk_out_d  = mode ? term : (clk_out_q ^ term);

        if (term) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + ONE_W;
        end

        // Apply only at a wrap, or immediately when frozen; either way restart from 0.
        if (pend_q && (term || !en)) begin
            half_d  = pend_val_q;
            pend_d  = 1'b0;
            count_d = '0;
        end

        // Capture is gated on !pend_q, so it never collides with the apply above;
        // a load accepted on a wrap cycle therefore waits for the following wrap.
        if (accept) begin
            pend_val_d = (load.load_half == '0) ? ONE_W : load.load_half;
            pend_d     = 1'b1;
        end
    end

`ifdef FDIV_TICK_CNT_EN
    // Free-running tick counter, wraps naturally at 16 bits.
    always_comb begin
        tick_cnt_d = tick_cnt_q + 16'(term);
    end
`endif

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            count_q    <= '0;
            half_q     <= RST_HALF_W;
            pend_val_q <= RST_HALF_W;
            pend_q     <= 1'b0;
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
`ifdef FDIV_TICK_CNT_EN
            tick_cnt_q <= '0;
`endif
        end else begin
            count_q    <= count_d;
            half_q     <= half_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
`ifdef FDIV_TICK_CNT_EN
            tick_cnt_q <= tick_cnt_d;
`endif
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
`ifdef FDIV_TICK_CNT_EN
    assign tick_cnt = tick_cnt_q;
`endif

endmodule

// File: tb/tb_f_div_prog.sv
// Testbench for f_div_prog with RST_HALF=5. A reference model advances on every
// driven cycle and queues the expected clk_out/tick/load_ready; each scenario pops
// and compares after the clock edge, plus fixed cycle-position checks.
module tb_f_div_prog;
    localparam int unsigned CNT_W    = 32;
    localparam int unsigned RST_HALF = 5;

    typedef struct packed {
        logic        clk_out;
        logic        tick;
        logic        ready;
        logic [15:0] cnt;
    } exp_t;

    logic        clk_50M = 1'b0;
    logic        reset;
    logic        en;
    logic        mode;
    logic        clk_out;
    logic        tick;
`ifdef FDIV_TICK_CNT_EN
    logic [15:0] tick_cnt;
`endif

    int tests = 0;
    int fails = 0;
    exp_t sb[$];

    logic [31:0] m_count, m_half, m_pend_val;
    logic        m_pend, m_clk, m_tick;
    logic [15:0] m_cnt16;

    f_div_prog_if #(.CNT_W(CNT_W)) bus ();

    always #5 clk_50M = ~clk_50M;

    f_div_prog #(.CNT_W(CNT_W), .RST_HALF(RST_HALF)) dut (
        .clk_50M (clk_50M),
        .reset   (reset),
        .en      (en),
        .mode    (mode),
        .load    (bus),
        .clk_out (clk_out),
        .tick    (tick)
`ifdef FDIV_TICK_CNT_EN
        ,
        .tick_cnt(tick_cnt)
`endif
    );

    // Drive one cycle at the negedge, advance the model, queue expectations, then
    // wait for the posedge and return at the following negedge.
    task automatic drive(input logic r, input logic e, input logic md, input logic v,
                         input logic [31:0] h, output logic acc);
        logic t;
        reset = r; en = e; mode = md;
        bus.load_valid = v; bus.load_half = h;
        acc = 1'b0;
        if (r) begin
            m_count = 0; m_half = RST_HALF; m_pend = 1'b0; m_pend_val = RST_HALF;
            m_clk = 1'b0; m_tick = 1'b0; m_cnt16 = '0;
        end else begin
            t   = e && (m_count == m_half - 1);
            acc = v && !m_pend;
            m_tick = t;
            m_clk  = md ? t : (m_clk ^ t);
            if (t) m_cnt16 = m_cnt16 + 16'd1;
            if (m_pend && (t || !e)) begin
                m_half = m_pend_val; m_pend = 1'b0; m_count = 0;
            end else if (t) begin
                m_count = 0;
            end else if (e) begin
                m_count = m_count + 1;
            end
            if (acc) begin
                m_pend_val = (h == 0) ? 32'd1 : h;
                m_pend = 1'b1;
            end
        end
        sb.push_back('{clk_out: m_clk, tick: m_tick, ready: !m_pend && !r, cnt: m_cnt16});
        @(posedge clk_50M);
        @(negedge clk_50M);
    endtask

    task automatic test_reset();
        exp_t x; logic acc;
        for (int c = 1; c <= 3; c++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1, 32'd9, acc);
            x = sb.pop_front();
            tests++;
            if ({clk_out, tick, bus.load_ready} !== {x.clk_out, x.tick, x.ready}) begin
                fails++;
                $display("FAIL reset_model c%0d: got clk_out/tick/ready=%b%b%b want %b%b%b",
                         c, clk_out, tick, bus.load_ready, x.clk_out, x.tick, x.ready);
            end
            tests++;
            if ({clk_out, tick, bus.load_ready} !== 3'b000) begin
                fails++;
                $display("FAIL reset_state c%0d: got %b%b%b want 000", c, clk_out, tick, bus.load_ready);
            end
        end
    endtask

    // Divide by 5 after reset: tick at 5,10,15; clk_out high 5-9, low 10-14.
    task automatic test_square();
        exp_t x; logic acc; logic want_clk, want_tick;
        for (int c = 1; c <= 16; c++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, acc);
            x = sb.pop_front();
            tests++;
            if ({clk_out, tick, bus.load_ready} !== {x.clk_out, x.tick, x.ready}) begin
                fails++;
                $display("FAIL square_model c%0d: got clk_out/tick/ready=%b%b%b want %b%b%b",
                         c, clk_out, tick, bus.load_ready, x.clk_out, x.tick, x.ready);
            end
            want_clk  = ((c >= 5 && c <= 9) || c >= 15);
            want_tick = (c % 5 == 0);
            tests++;
            if ({clk_out, tick, bus.load_ready} !== {want_clk, want_tick, 1'b1}) begin
                fails++;
                $display("FAIL square_fixed c%0d: got %b%b%b want %b%b1",
                         c, clk_out, tick, bus.load_ready, want_clk, want_tick);
            end
        end
    endtask

    // Load 3 at count=2: ready low after c3,c4; apply at c5; ticks 5,8,11,14.
    task automatic test_load_mid();
        exp_t x; logic acc;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, acc);
        void'(sb.pop_front());
        for (int c = 1; c <= 14; c++) begin
            drive(1'b0, 1'b1, 1'b0, (c == 3), 32'd3, acc);
            x = sb.pop_front();
            tests++;
            if ({clk_out, tick, bus.load_ready} !== {x.clk_out, x.tick, x.ready}) begin
                fails++;
                $display("FAIL load_mid_model c%0d: got clk_out/tick/ready=%b%b%b want %b%b%b",
                         c, clk_out, tick, bus.load_ready, x.clk_out, x.tick, x.ready);
            end
            tests++;
            if ({tick, bus.load_ready} !== {(c == 5 || c == 8 || c == 11 || c == 14),
                                            !(c == 3 || c == 4)}) begin
                fails++;
                $display("FAIL load_mid_fixed c%0d: got tick/ready=%b%b", c, tick, bus.load_ready);
            end
        end
    endtask

    // Load 0 behaves as 1: tick stays high, clk_out toggles every cycle.
    task automatic test_zero();
        exp_t x; logic acc;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, acc);
        void'(sb.pop_front());
        for (int c = 1; c <= 12; c++) begin
            drive(1'b0, 1'b1, 1'b0, (c == 1), 32'd0, acc);
            x = sb.pop_front();
            tests++;
            if ({clk_out, tick, bus.load_ready} !== {x.clk_out, x.tick, x.ready}) begin
                fails++;
                $display("FAIL zero_model c%0d: got clk_out/tick/ready=%b%b%b want %b%b%b",
                         c, clk_out, tick, bus.load_ready, x.clk_out, x.tick, x.ready);
            end
            if (c >= 5) begin
                tests++;
                if (tick !== 1'b1 || clk_out !== ((c % 2) == 1)) begin
                    fails++;
                    $display("FAIL zero_fixed c%0d: got tick/clk_out=%b%b want 1%b",
                             c, tick, clk_out, ((c % 2) == 1));
                end
            end
        end
    endtask

    // Strobe mode at half=4, a 10-cycle freeze, then a switch back to square mode.
    task automatic test_strobe_freeze();
        exp_t x; logic acc; logic e, md;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, acc);
        void'(sb.pop_front());
        for (int c = 1; c <= 40; c++) begin
            e  = !(c >= 15 && c <= 24);
            md = (c <= 32);
            drive(1'b0, e, md, (c == 1), 32'd4, acc);
            x = sb.pop_front();
            tests++;
            if ({clk_out, tick, bus.load_ready} !== {x.clk_out, x.tick, x.ready}) begin
                fails++;
                $display("FAIL strobe_model c%0d: got clk_out/tick/ready=%b%b%b want %b%b%b",
                         c, clk_out, tick, bus.load_ready, x.clk_out, x.tick, x.ready);
            end
            if (md) begin
                tests++;
                if (clk_out !== tick || (!e && clk_out !== 1'b0)) begin
                    fails++;
                    $display("FAIL strobe_fixed c%0d: got clk_out/tick=%b%b", c, clk_out, tick);
                end
            end
        end
    endtask

    // Load 7 while frozen applies next cycle; a held load waits for ready.
    task automatic test_load_disabled();
        exp_t x; logic acc; logic e, v; logic [31:0] h;
        logic holding;
        holding = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, acc);
        void'(sb.pop_front());
        for (int c = 1; c <= 30; c++) begin
            e = !(c == 3 || c == 4);
            if (c == 12) holding = 1'b1;
            v = (c == 3) || (c >= 12 && holding);
            h = (c == 3) ? 32'd7 : (c == 12) ? 32'd2 : 32'd9;
            drive(1'b0, e, 1'b0, v, h, acc);
            if (acc && c > 12) holding = 1'b0;
            x = sb.pop_front();
            tests++;
            if ({clk_out, tick, bus.load_ready} !== {x.clk_out, x.tick, x.ready}) begin
                fails++;
                $display("FAIL load_dis_model c%0d: got clk_out/tick/ready=%b%b%b want %b%b%b",
                         c, clk_out, tick, bus.load_ready, x.clk_out, x.tick, x.ready);
            end
            if (c <= 11) begin
                tests++;
                if ({tick, bus.load_ready} !== {(c == 11), (c != 3)}) begin
                    fails++;
                    $display("FAIL load_dis_fixed c%0d: got tick/ready=%b%b", c, tick, bus.load_ready);
                end
            end
        end
    endtask

    // Reset with a pending load at count=3 discards it; the period restarts at 5.
    task automatic test_reset_pending();
        exp_t x; logic acc;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, acc);
        void'(sb.pop_front());
        for (int c = 1; c <= 12; c++) begin
            drive((c == 4), 1'b1, 1'b0, (c == 1), 32'd6, acc);
            x = sb.pop_front();
            tests++;
            if ({clk_out, tick, bus.load_ready} !== {x.clk_out, x.tick, x.ready}) begin
                fails++;
                $display("FAIL rst_pend_model c%0d: got clk_out/tick/ready=%b%b%b want %b%b%b",
                         c, clk_out, tick, bus.load_ready, x.clk_out, x.tick, x.ready);
            end
            if (c >= 4) begin
                tests++;
                if ({tick, bus.load_ready} !== {(c == 9), (c != 4)}) begin
                    fails++;
                    $display("FAIL rst_pend_fixed c%0d: got tick/ready=%b%b", c, tick, bus.load_ready);
                end
            end
        end
    endtask

`ifdef FDIV_TICK_CNT_EN
    // Half=1 from c5 onward: 65536 ticks by c65540 wraps the counter to 0.
    task automatic test_tick_wrap();
        exp_t x; logic acc;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, acc);
        void'(sb.pop_front());
        for (int c = 1; c <= 65542; c++) begin
            drive(1'b0, 1'b1, 1'b0, (c == 1), 32'd0, acc);
            x = sb.pop_front();
            tests++;
            if (tick_cnt !== x.cnt) begin
                fails++;
                $display("FAIL tick_cnt_model c%0d: got %0d want %0d", c, tick_cnt, x.cnt);
            end
            if (c == 65540) begin
                tests++;
                if (tick_cnt !== 16'd0) begin
                    fails++;
                    $display("FAIL tick_cnt_wrap: got %0d want 0", tick_cnt);
                end
            end
        end
    endtask
`endif

    initial begin
        reset = 1'b1; en = 1'b0; mode = 1'b0;
        bus.load_valid = 1'b0; bus.load_half = '0;
        @(negedge clk_50M);
        test_reset();
        test_square();
        test_load_mid();
        test_zero();
        test_strobe_freeze();
        test_load_disabled();
        test_reset_pending();
`ifdef FDIV_TICK_CNT_EN
        test_tick_wrap();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
